load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, DataMem word-index width (128 words).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Req  in  1  pipeline request strobe, accepted only in IDLE.
REQ-005 IsStore  in  1  1=store, 0=load; sampled with Req.
REQ-006 MemOp  in  3  MIPS opcode[2:0]: 000 b, 001 h, 011 w, 100 bu, 101 hu; sampled with Req.
REQ-007 Addr  in  32  byte address; sampled with Req.
REQ-008 StoreData  in  32  store operand, low bits used for b/h; sampled with Req.
REQ-009 Busy  out  1  high in every state except IDLE.
REQ-010 Done  out  1  one-cycle completion pulse.
REQ-011 Err  out  1  valid with Done; misaligned, out-of-range or illegal MemOp.
REQ-012 LoadData  out  32  extended load result, valid with Done, held until next Done.
REQ-013 Address  out  ADDR_W  to DataMem, word index = Addr[ADDR_W+1:2].
REQ-014 WriteData  out  32  to DataMem.
REQ-015 MemWrite  out  1  to DataMem, sampled there on rising clk.
REQ-016 MemRead  out  1  to DataMem.
REQ-017 ReadData  in  32  from DataMem, valid in the same cycle MemRead is high.

Function
REQ-018 SHALL use states IDLE, READ, MERGE, WRITE, DONE.
REQ-019 IDLE with Req=1 SHALL latch IsStore/MemOp/Addr/StoreData and go: Err case -> DONE; load or sb/sh -> READ; sw -> WRITE.
REQ-020 READ SHALL drive MemRead=1, capture ReadData at the clock edge ending the cycle, then go DONE for loads and MERGE for sb/sh.
REQ-021 MERGE SHALL replace the addressed byte/halfword of the captured word with StoreData[7:0]/[15:0], then go WRITE.
REQ-022 WRITE SHALL drive MemWrite=1 for exactly one cycle with the merged word (sb/sh) or StoreData (sw), then go DONE.
REQ-023 DONE SHALL pulse Done=1 for one cycle, then return to IDLE; Req is ignored in DONE.
REQ-024 Latency from the accept edge to Done SHALL be: lw/lb/lh/lbu/lhu 2 cycles, sw 2, sb/sh 4, error 1.
REQ-025 Byte order SHALL be big-endian: Addr[1:0]=0 selects bits [31:24]; halfword Addr[1]=0 selects [31:16].
REQ-026 lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend to 32 bits.
REQ-027 Err SHALL be set, with no memory strobe, on: lh/lhu/sh with Addr[0]=1; lw/sw with Addr[1:0]!=0; Addr[31:ADDR_W+2]!=0; MemOp in {010,110,111} or store with MemOp[2]=1.
REQ-028 On Err, LoadData SHALL keep its previous value.
REQ-029 MemRead and MemWrite SHALL never both be high, and both SHALL be low in IDLE, MERGE and DONE.
REQ-030 Address/WriteData SHALL be stable for the whole READ..WRITE sequence of one request.

Reset
REQ-031 With rst_n=0 at a rising edge: state=IDLE, Busy=0, Done=0, Err=0, LoadData=0, MemWrite=0, MemRead=0, Address=0, WriteData=0.
REQ-032 Reset mid-operation SHALL abort immediately; a pending MERGE/WRITE SHALL NOT write memory.

Structure
REQ-033 MemOp codes and state encodings SHALL live in a shared MIPS constants include (lsu_defs), reused by the decoder.
REQ-034 Byte-lane extract/extend and merge SHALL be one combinational sub-module, lsu_align.
REQ-035 DataMem SHALL be instantiated by the MEM-stage top, not inside this block.

Verification (bench instantiates DataMem + load_store_unit)
REQ-036 sw Addr=0x10, StoreData=0xDEADBEEF; then lw 0x10 -> Done at +2, LoadData=0xDEADBEEF, Err=0.
REQ-037 After REQ-036, lb 0x13 -> 0xFFFFFFEF; lbu 0x12 -> 0x000000BE; lh 0x10 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000BEEF.
REQ-038 sb 0x11 with StoreData=0x12 -> Done at +4, exactly one MemWrite pulse; then lw 0x10 -> 0xDE12BEEF.
REQ-039 lw 0x12, then sh 0x11, then lw 0x200 -> each gives Done+Err at +1, no MemRead/MemWrite, LoadData unchanged.
REQ-040 sh 0x14 with rst_n=0 in the MERGE cycle -> outputs at reset values next cycle, word 5 unchanged.
REQ-041 Req held high continuously through 3 loads -> each accepted only in IDLE, Busy high between accepts, 3 Done pulses.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared MIPS load/store constants: MemOp encodings (opcode[2:0]), the LSU
// state encoding, and the request legality check used by the decoder.
// No ports (package).
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int MEMOP_W = 3;

    // MIPS opcode[2:0] for the supported memory operations
    localparam logic [MEMOP_W-1:0] OP_B  = 3'b000;
    localparam logic [MEMOP_W-1:0] OP_H  = 3'b001;
    localparam logic [MEMOP_W-1:0] OP_W  = 3'b011;
    localparam logic [MEMOP_W-1:0] OP_BU = 3'b100;
    localparam logic [MEMOP_W-1:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } lsu_state_e;

    // A request is rejected when its opcode is unknown, when a store asks for
    // an unsigned (load-only) variant, when the address is not naturally
    // aligned for the access size, or when it points beyond DataMem.
    function automatic logic lsu_op_error(input logic               isStore,
                                          input logic [MEMOP_W-1:0] memOp,
                                          input logic [31:0]        addr,
                                          input int                 addrW);
        logic bad;
        bad = 1'b0;
        case (memOp)
            OP_B, OP_BU: bad = 1'b0;
            OP_H, OP_HU: bad = addr[0];
            OP_W:        bad = (addr[1:0] != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (isStore && memOp[2]) begin
            bad = 1'b1;
        end
        if ((addr >> (addrW + 2)) != 32'd0) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the pipeline request/response signals and the DataMem bus of the
// load/store unit.
//   master : pipeline + DataMem side (drives Req/IsStore/MemOp/Addr/StoreData
//            and ReadData, observes everything the LSU produces)
//   slave  : the load/store unit itself
// Parameter ADDR_W : DataMem word-index width.
// ---------------------------------------------------------------------------
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 7
);
    logic               Req;
    logic               IsStore;
    logic [MEMOP_W-1:0] MemOp;
    logic [31:0]        Addr;
    logic [31:0]        StoreData;
    logic               Busy;
    logic               Done;
    logic               Err;
    logic [31:0]        LoadData;
    logic [ADDR_W-1:0]  Address;
    logic [31:0]        WriteData;
    logic               MemWrite;
    logic               MemRead;
    logic [31:0]        ReadData;

    modport master (
        output Req, IsStore, MemOp, Addr, StoreData, ReadData,
        input  Busy, Done, Err, LoadData, Address, WriteData, MemWrite, MemRead
    );

    modport slave (
        input  Req, IsStore, MemOp, Addr, StoreData, ReadData,
        output Busy, Done, Err, LoadData, Address, WriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for a big-endian 32-bit word:
// extracts and sign/zero-extends a byte/halfword for loads, and merges a
// byte/halfword of store data into an existing word for sub-word stores.
//   i_memOp      : MemOp of the current request
//   i_byteOff    : Addr[1:0] of the current request
//   i_readWord   : word being loaded (extract source)
//   i_oldWord    : previously read word (merge destination)
//   i_storeData  : store operand (low bits used for b/h)
//   o_loadData   : extended load result
//   o_mergedWord : word to write back (store data itself for sw)
// ---------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [MEMOP_W-1:0] i_memOp,
    input  logic [1:0]         i_byteOff,
    input  logic [31:0]        i_readWord,
    input  logic [31:0]        i_oldWord,
    input  logic [31:0]        i_storeData,
    output logic [31:0]        o_loadData,
    output logic [31:0]        o_mergedWord
);

    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_byteMask;
    logic [31:0] w_halfMask;
    logic [31:0] w_byteIns;
    logic [31:0] w_halfIns;

    // Big-endian lanes: offset 0 is the most significant byte, so the shift
    // to bring a byte down to bit 0 is (3 - offset) * 8.
    always_comb begin
        w_shift    = {~i_byteOff, 3'b000};
        w_byte     = 8'(i_readWord >> w_shift);
        w_half     = i_byteOff[1] ? i_readWord[15:0] : i_readWord[31:16];
        w_byteMask = 32'h0000_00FF << w_shift;
        w_halfMask = i_byteOff[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        w_byteIns  = {24'd0, i_storeData[7:0]} << w_shift;
        w_halfIns  = i_byteOff[1] ? {16'd0, i_storeData[15:0]}
                                  : {i_storeData[15:0], 16'd0};
    end

    // Load path: signed variants replicate the top bit of the selected lane.
    always_comb begin
        o_loadData = i_readWord;
        case (i_memOp)
            OP_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
            OP_BU:   o_loadData = {24'd0, w_byte};
            OP_H:    o_loadData = {{16{w_half[15]}}, w_half};
            OP_HU:   o_loadData = {16'd0, w_half};
            default: o_loadData = i_readWord;
        endcase
    end

    // Store path: only sb/sh need a read-modify-write merge.
    always_comb begin
        o_mergedWord = i_storeData;
        case (i_memOp)
            OP_B:    o_mergedWord = (i_oldWord & ~w_byteMask) | w_byteIns;
            OP_H:    o_mergedWord = (i_oldWord & ~w_halfMask) | w_halfIns;
            default: o_mergedWord = i_storeData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage load/store sequencer in front of a single-port word DataMem.
// Loads read one word and extend the addressed lane; sw writes directly;
// sb/sh do read-merge-write. Illegal requests finish with Err and touch no
// memory. DataMem itself lives outside this block.
//   clk   : single clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and DataMem bus)
// Parameter ADDR_W : DataMem word-index width.
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    lsu_state_e         r_state;
    lsu_state_e         w_nextState;
    logic               w_accept;
    logic               w_reqErr;
    logic               r_isStore;
    logic [MEMOP_W-1:0] r_memOp;
    logic [1:0]         r_byteOff;
    logic [ADDR_W-1:0]  r_wordIdx;
    logic [31:0]        r_storeData;
    logic [31:0]        r_readWord;
    logic [31:0]        r_writeData;
    logic [31:0]        r_loadData;
    logic               r_err;
    logic [31:0]        w_loadData;
    logic [31:0]        w_mergedWord;

    assign w_reqErr = lsu_op_error(bus.IsStore, bus.MemOp, bus.Addr, ADDR_W);

    lsu_align u_align (
        .i_memOp      (r_memOp),
        .i_byteOff    (r_byteOff),
        .i_readWord   (bus.ReadData),
        .i_oldWord    (r_readWord),
        .i_storeData  (r_storeData),
        .o_loadData   (w_loadData),
        .o_mergedWord (w_mergedWord)
    );

    // Next-state logic. Requests are only looked at in IDLE, so a Req held
    // high is simply re-accepted each time the unit comes back to IDLE.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.Req) begin
                    w_accept = 1'b1;
                    if (w_reqErr) begin
                        w_nextState = DONE;
                    end else if (bus.IsStore && (bus.MemOp == OP_W)) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = READ;
                    end
                end
            end
            READ:    w_nextState = r_isStore ? MERGE : DONE;
            MERGE:   w_nextState = WRITE;
            WRITE:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State and datapath registers. The request is captured once on accept,
    // so Address stays fixed for the whole request. Reset drops straight to
    // IDLE, which removes any pending write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_isStore   <= 1'b0;
            r_memOp     <= '0;
            r_byteOff   <= '0;
            r_wordIdx   <= '0;
            r_storeData <= '0;
            r_readWord  <= '0;
            r_writeData <= '0;
            r_loadData  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_isStore   <= bus.IsStore;
                r_memOp     <= bus.MemOp;
                r_byteOff   <= bus.Addr[1:0];
                r_wordIdx   <= bus.Addr[ADDR_W+1:2];
                r_storeData <= bus.StoreData;
                r_writeData <= bus.StoreData;
                r_err       <= w_reqErr;
            end
            if (r_state == READ) begin
                r_readWord <= bus.ReadData;
                if (!r_isStore) begin
                    r_loadData <= w_loadData;
                end
            end
            if (r_state == MERGE) begin
                r_writeData <= w_mergedWord;
            end
        end
    end

    // Strobes decode straight from the state, so read and write can never
    // overlap and both are low outside READ/WRITE.
    assign bus.Busy      = (r_state != IDLE);
    assign bus.Done      = (r_state == DONE);
    assign bus.Err       = (r_state == DONE) && r_err;
    assign bus.MemRead   = (r_state == READ);
    assign bus.MemWrite  = (r_state == WRITE);
    assign bus.LoadData  = r_loadData;
    assign bus.Address   = r_wordIdx;
    assign bus.WriteData = r_writeData;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Bench for load_store_unit with a 128-word DataMem model. Expected results
// come from a byte-array reference memory and plain size/alignment rules.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int ADDR_W    = 7;
    localparam int MEM_BYTES = 4 << ADDR_W;

    logic clk;
    logic rst_n;
    logic memClear;
    int   testsRun;
    int   testsFailed;

    logic [31:0] dmem    [0:(1<<ADDR_W)-1];
    logic [7:0]  refMem  [0:MEM_BYTES-1];
    logic [31:0] lastLoad;

    typedef struct {
        logic        isStore;
        logic [2:0]  memOp;
        logic [31:0] addr;
        logic [31:0] storeData;
        logic        expErr;
        int          expLat;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [11];

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMem model: asynchronous read, write on the rising edge.
    assign bus.ReadData = dmem[bus.Address];

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < (1 << ADDR_W); i++) dmem[i] <= '0;
        end else if (bus.MemWrite) begin
            dmem[bus.Address] <= bus.WriteData;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired, tests=%0d failed=%0d", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int opSize(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: return 1;
            OP_H, OP_HU: return 2;
            OP_W:        return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic modelErr(input logic isStore, input logic [2:0] op,
                                      input logic [31:0] addr);
        int size;
        size = opSize(op);
        if (size == 0) return 1'b1;
        if (isStore && (op == OP_BU || op == OP_HU)) return 1'b1;
        if (addr >= 32'(MEM_BYTES)) return 1'b1;
        if ((addr % 32'(size)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int modelLat(input logic isStore, input logic [2:0] op,
                                    input logic [31:0] addr);
        if (modelErr(isStore, op, addr)) return 1;
        if (!isStore) return 2;
        if (opSize(op) == 4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] v;
        int size;
        size = opSize(op);
        v = 0;
        for (int i = 0; i < size; i++) v = (v << 8) + 32'(refMem[addr + 32'(i)]);
        if (op == OP_B && v >= 32'd128) v = v - 32'd256;
        if (op == OP_H && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic modelApply(input logic isStore, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] sd);
        int size;
        size = opSize(op);
        if (modelErr(isStore, op, addr)) return;
        if (isStore) begin
            for (int i = 0; i < size; i++)
                refMem[addr + 32'(i)] = 8'(sd >> (8 * (size - 1 - i)));
        end else begin
            lastLoad = modelLoad(op, addr);
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one request from IDLE and follows it to Done (bounded), counting
    // memory strobes seen on the way. Returns one cycle later, back in IDLE.
    task automatic applyStimulus(input logic isStore, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 output int lat, output logic err, output logic [31:0] data,
                                 output int nRead, output int nWrite);
        bus.Req       = 1'b1;
        bus.IsStore   = isStore;
        bus.MemOp     = op;
        bus.Addr      = addr;
        bus.StoreData = sd;
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        lat     = 1;
        nRead   = 0;
        nWrite  = 0;
        while (!bus.Done && lat < 12) begin
            nRead  += int'(bus.MemRead);
            nWrite += int'(bus.MemWrite);
            @(posedge clk);
            #1;
            lat++;
        end
        err  = bus.Err;
        data = bus.LoadData;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic isStore, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic expErr, input int expLat, input logic [31:0] expData);
        int lat, nRead, nWrite;
        logic err;
        logic [31:0] data;
        applyStimulus(isStore, op, addr, sd, lat, err, data, nRead, nWrite);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " Err"}, 32'(err), 32'(expErr));
        checkOutput({tag, " LoadData"}, data, expData);
        checkOutput({tag, " MemRead count"}, 32'(nRead),
                    32'((!expErr && (!isStore || expLat == 4)) ? 1 : 0));
        checkOutput({tag, " MemWrite count"}, 32'(nWrite), 32'((!expErr && isStore) ? 1 : 0));
        modelApply(isStore, op, addr, sd);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " Busy"}, 32'(bus.Busy), 32'd0);
        checkOutput({tag, " Done"}, 32'(bus.Done), 32'd0);
        checkOutput({tag, " Err"}, 32'(bus.Err), 32'd0);
        checkOutput({tag, " LoadData"}, bus.LoadData, 32'd0);
        checkOutput({tag, " MemWrite"}, 32'(bus.MemWrite), 32'd0);
        checkOutput({tag, " MemRead"}, 32'(bus.MemRead), 32'd0);
        checkOutput({tag, " Address"}, 32'(bus.Address), 32'd0);
        checkOutput({tag, " WriteData"}, bus.WriteData, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [2:0]  rOp;
        logic [31:0] rAddr, rSd, rExpData;
        logic        rStore, rExpErr;
        int          doneCnt, readCnt;

        testsRun    = 0;
        testsFailed = 0;
        lastLoad    = '0;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h00;

        vecs[0]  = '{1'b1, OP_W,  32'h10,  32'hDEADBEEF, 1'b0, 2, 32'h0000_0000};
        vecs[1]  = '{1'b0, OP_W,  32'h10,  32'h0,        1'b0, 2, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, OP_B,  32'h13,  32'h0,        1'b0, 2, 32'hFFFF_FFEF};
        vecs[3]  = '{1'b0, OP_BU, 32'h12,  32'h0,        1'b0, 2, 32'h0000_00BE};
        vecs[4]  = '{1'b0, OP_H,  32'h10,  32'h0,        1'b0, 2, 32'hFFFF_DEAD};
        vecs[5]  = '{1'b0, OP_HU, 32'h12,  32'h0,        1'b0, 2, 32'h0000_BEEF};
        vecs[6]  = '{1'b1, OP_B,  32'h11,  32'h12,       1'b0, 4, 32'h0000_BEEF};
        vecs[7]  = '{1'b0, OP_W,  32'h10,  32'h0,        1'b0, 2, 32'hDE12_BEEF};
        vecs[8]  = '{1'b0, OP_W,  32'h12,  32'h0,        1'b1, 1, 32'hDE12_BEEF};
        vecs[9]  = '{1'b1, OP_H,  32'h11,  32'h5555,     1'b1, 1, 32'hDE12_BEEF};
        vecs[10] = '{1'b0, OP_W,  32'h200, 32'h0,        1'b1, 1, 32'hDE12_BEEF};

        bus.Req       = 1'b0;
        bus.IsStore   = 1'b0;
        bus.MemOp     = '0;
        bus.Addr      = '0;
        bus.StoreData = '0;
        memClear      = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        memClear = 1'b0;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].isStore, vecs[i].memOp, vecs[i].addr,
                  vecs[i].storeData, vecs[i].expErr, vecs[i].expLat, vecs[i].expData);
        end

        // sh into word 5, reset asserted while in MERGE: nothing may be written.
        bus.Req       = 1'b1;
        bus.IsStore   = 1'b1;
        bus.MemOp     = OP_H;
        bus.Addr      = 32'h14;
        bus.StoreData = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        bus.Req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("abort");
        rst_n    = 1'b1;
        lastLoad = '0;
        checkOutput("abort word5 in DataMem", dmem[5], 32'h0);
        runOp("abort readback", 1'b0, OP_W, 32'h14, 32'h0, 1'b0, 2, modelLoad(OP_W, 32'h14));

        // Req held high: each load takes READ, DONE, then one IDLE cycle.
        bus.Req     = 1'b1;
        bus.IsStore = 1'b0;
        bus.MemOp   = OP_W;
        bus.Addr    = 32'h10;
        doneCnt     = 0;
        readCnt     = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("held cycle%0d Busy", k), 32'(bus.Busy), 32'((k % 3 != 0) ? 1 : 0));
            checkOutput($sformatf("held cycle%0d Done", k), 32'(bus.Done), 32'((k % 3 == 2) ? 1 : 0));
            doneCnt += int'(bus.Done);
            readCnt += int'(bus.MemRead);
        end
        bus.Req = 1'b0;
        checkOutput("held Done pulses", 32'(doneCnt), 32'd3);
        checkOutput("held MemRead cycles", 32'(readCnt), 32'd3);
        lastLoad = modelLoad(OP_W, 32'h10);
        checkOutput("held LoadData", bus.LoadData, lastLoad);

        // Random traffic against the reference model, concentrated on the low
        // 64 bytes so loads see earlier stores.
        for (int n = 0; n < 40; n++) begin
            rStore = 1'($urandom_range(0, 1));
            rOp    = 3'($urandom_range(0, 7));
            rSd    = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                rAddr = 32'h200 + $urandom_range(0, 32'h0FFF);
            end else begin
                rAddr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) rAddr = rAddr & ~32'(opSize(rOp) - 1);
            end
            rExpErr  = modelErr(rStore, rOp, rAddr);
            rExpData = (!rExpErr && !rStore) ? modelLoad(rOp, rAddr) : lastLoad;
            runOp($sformatf("rnd%0d op%0d st%0d a%h", n, rOp, rStore, rAddr),
                  rStore, rOp, rAddr, rSd, rExpErr, modelLat(rStore, rOp, rAddr), rExpData);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
